bsg_mux_bitwise_fifo: RTL

BSG_MUX_BITWISE_FIFO -- requirements
Module: bsg_mux_bitwise_fifo

---
 rtl/bsg_defines.sv | 7 +
 rtl/bsg_mux_bitwise.sv | 11 +
 rtl/bsg_mux_bitwise_fifo.sv | 74 +++++++
 3 files changed

// File: rtl/bsg_defines.sv
// bsg_defines: shared occupancy state encoding and pointer-width helper
package bsg_defines;
    typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} fifo_state_e;
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/bsg_mux_bitwise.sv
// bsg_mux_bitwise: per-bit select between two words, sel=1 picks data1_i
module bsg_mux_bitwise #(
    parameter int width_p = 32
) (
    input  logic [width_p-1:0] data0_i,
    input  logic [width_p-1:0] data1_i,
    input  logic [width_p-1:0] sel_i,
    output logic [width_p-1:0] data_o
);
    assign data_o = (data0_i & ~sel_i) | (data1_i & sel_i);
endmodule

// File: rtl/bsg_mux_bitwise_fifo.sv
// bsg_mux_bitwise_fifo: buffers the bitwise merge of two words in a registered FIFO
module bsg_mux_bitwise_fifo
    import bsg_defines::*;
#(
    parameter int width_p = 32,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    output logic               ready_o,
    input  logic [width_p-1:0] data0_i,
    input  logic [width_p-1:0] data1_i,
    input  logic [width_p-1:0] sel_i,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);
    localparam int PW = safe_clog2(els_p);
    localparam int CW = safe_clog2(els_p + 1);

    fifo_state_e       state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     rptr_q, rptr_d, wptr_q, wptr_d;
    logic [width_p-1:0] mem_q [els_p];
    logic [width_p-1:0] merged;
    logic              enq, deq;

    bsg_mux_bitwise #(.width_p(width_p)) mux (
        .data0_i(data0_i),
        .data1_i(data1_i),
        .sel_i  (sel_i),
        .data_o (merged)
    );

    // flags come from the registered state, so no yumi-to-ready bypass exists
    assign ready_o = state_q != FULL;
    assign v_o     = state_q != EMPTY;
    assign data_o  = mem_q[rptr_q];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    always_comb begin
        count_d = count_q + CW'(enq) - CW'(deq);
        wptr_d  = enq ? ((wptr_q == PW'(els_p - 1)) ? '0 : wptr_q + 1'b1) : wptr_q;
        rptr_d  = deq ? ((rptr_q == PW'(els_p - 1)) ? '0 : rptr_q + 1'b1) : rptr_q;
        state_d = (count_d == '0) ? EMPTY : (count_d == CW'(els_p)) ? FULL : PARTIAL;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= EMPTY;
            count_q <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq && !reset_i) mem_q[wptr_q] <= merged;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !v_o));
            assert (count_q <= CW'(els_p));
        end
    end
endmodule
